// File: rtl/division_repeated_sub_if.sv
// Operand/result handshake bundle for the repeated-subtraction divider.
// The slave modport is the divider's view; master is the requester's view.
interface division_repeated_sub_if #(
  parameter int unsigned N_WIDTH = 8,
  parameter int unsigned D_WIDTH = 4
);

  logic [N_WIDTH-1:0] in_dividend;
  logic [D_WIDTH-1:0] in_divisor;
  logic               valid_in;
  logic               ready_out;
  logic [N_WIDTH-1:0] quot_out;
  logic [D_WIDTH-1:0] rem_out;
  logic               div_by_zero;
  logic               valid_out;
  logic               ready_in;

  modport slave (
    input  in_dividend,
    input  in_divisor,
    input  valid_in,
    output ready_out,
    output quot_out,
    output rem_out,
    output div_by_zero,
    output valid_out,
    input  ready_in
  );

  modport master (
    output in_dividend,
    output in_divisor,
    output valid_in,
    input  ready_out,
    input  quot_out,
    input  rem_out,
    input  div_by_zero,
    input  valid_out,
    output ready_in
  );

endinterface

// File: rtl/division_repeated_sub.sv
// Unsigned divider by repeated subtraction: one subtract per cycle, quotient counts the steps.
// Results are held under downstream backpressure and stay visible until the next result.
module division_repeated_sub #(
  parameter int unsigned N_WIDTH = 8,
  parameter int unsigned D_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  division_repeated_sub_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_WIDTH-1:0] rem_tmp_q, rem_tmp_d;
  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic [D_WIDTH-1:0] div_q, div_d;
  logic [N_WIDTH-1:0] quot_q, quot_d;
  logic [D_WIDTH-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic [N_WIDTH-1:0] div_ext;

  assign div_ext = N_WIDTH'(div_q);

  always_comb begin
    state_d   = state_q;
    rem_tmp_d = rem_tmp_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          div_d     = bus.in_divisor;
          rem_tmp_d = bus.in_dividend;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (div_q == '0) begin
          quot_d  = '1;
          rem_d   = '0;
          dbz_d   = 1'b1;
          state_d = StDone;
        end else if (rem_tmp_q >= div_ext) begin
          rem_tmp_d = rem_tmp_q - div_ext;
          cnt_d     = cnt_q + N_WIDTH'(1);
        end else begin
          // rem_tmp < d, so it already fits in D_WIDTH bits
          quot_d  = cnt_q;
          rem_d   = rem_tmp_q[D_WIDTH-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.ready_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_tmp_q <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_tmp_q <= rem_tmp_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  // Handshake flags decode straight from state so they can never both be high.
  assign bus.ready_out   = (state_q == StIdle);
  assign bus.valid_out   = (state_q == StDone);
  assign bus.quot_out    = quot_q;
  assign bus.rem_out     = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
